// File: rtl/rv_memory.sv
// rv_memory: memory-access stage between execute and write-back.
// Single-outstanding req/ack data bus, load align/extend, stall, faults.
module rv_memory #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_alu_result,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [4:0]  i_rd,
  input  logic [29:0] i_pc_p4,
  input  logic [1:0]  i_res_src,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs2_val,
  input  logic        i_dbus_ack,
  input  logic        i_dbus_err,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [29:0] o_dbus_addr,
  output logic [3:0]  o_dbus_be,
  output logic [31:0] o_dbus_wdata,
  output logic        o_stall,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic [1:0]  o_res_src,
  output logic [29:0] o_pc_p4,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_mem_data,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic [29:0] pc;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] rs2;
  } stage_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LIMI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW:0] LIM = (CW+1)'(LIMI);

  stage_t        s_q, s_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          fpend_q, fpend_d;

  logic       memop;
  logic       mis;
  logic       aborted;
  logic       req;
  logic       hit;
  logic       kill;
  logic [1:0] a;
  logic [7:0] lbyte;
  logic [15:0] lhalf;

  assign a       = s_q.alu[1:0];
  assign memop   = s_q.valid & (s_q.mr | s_q.mw);
  assign aborted = (state_q == S_ABORT);
  assign mis     = memop &
                   (((s_q.f3[1:0] == 2'b01) & a[0]) |
                    ((s_q.f3[1:0] == 2'b10) & (a != 2'b00)));
  assign req     = memop & ~mis & ~aborted;
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
  assign hit     = (TIMEOUT != 0) && (cnt_inc >= LIM);
  assign kill    = fpend_q | (i_flush & req & i_dbus_ack);

  assign o_dbus_req   = req;
  assign o_dbus_we    = s_q.mw;
  assign o_dbus_addr  = s_q.alu[31:2];
  assign o_stall      = req & ~i_dbus_ack;
  assign o_misalign   = mis;
  assign o_bus_err    = aborted | (req & i_dbus_ack & i_dbus_err);
  assign o_rd         = s_q.rd;
  assign o_res_src    = s_q.rs;
  assign o_pc_p4      = s_q.pc;
  assign o_alu_result = s_q.alu;
  assign o_reg_write  = s_q.rw & ~o_stall & ~mis &
                        ~o_bus_err & ~kill;

  // Byte enables and lane-replicated store data
  always_comb begin
    o_dbus_be    = 4'b0000;
    o_dbus_wdata = 32'h0;
    if (memop) begin
      unique case (s_q.f3[1:0])
        2'b00:   o_dbus_be = 4'b0001 << a;
        2'b01:   o_dbus_be = 4'b0011 << a;
        default: o_dbus_be = 4'b1111;
      endcase
    end
    if (memop & s_q.mw) begin
      unique case (s_q.f3[1:0])
        2'b00:   o_dbus_wdata = {4{s_q.rs2[7:0]}};
        2'b01:   o_dbus_wdata = {2{s_q.rs2[15:0]}};
        default: o_dbus_wdata = s_q.rs2;
      endcase
    end
  end

  // Load lane select and sign/zero extension
  always_comb begin
    lbyte      = i_dbus_rdata[7:0];
    lhalf      = a[1] ? i_dbus_rdata[31:16]
                      : i_dbus_rdata[15:0];
    o_mem_data = 32'h0;
    unique case (a)
      2'd0: lbyte = i_dbus_rdata[7:0];
      2'd1: lbyte = i_dbus_rdata[15:8];
      2'd2: lbyte = i_dbus_rdata[23:16];
      default: lbyte = i_dbus_rdata[31:24];
    endcase
    if (memop & s_q.mr & i_dbus_ack) begin
      unique case (s_q.f3)
        3'b000:  o_mem_data = {{24{lbyte[7]}}, lbyte};
        3'b001:  o_mem_data = {{16{lhalf[15]}}, lhalf};
        3'b010:  o_mem_data = i_dbus_rdata;
        3'b100:  o_mem_data = {24'h0, lbyte};
        3'b101:  o_mem_data = {16'h0, lhalf};
        default: o_mem_data = 32'h0;
      endcase
    end
  end

  // Next stage contents: a flushed slot becomes an all-zero bubble
  always_comb begin
    s_d       = '0;
    s_d.valid = 1'b1;
    s_d.alu   = i_alu_result;
    s_d.rw    = i_reg_write;
    s_d.mr    = i_mem_read;
    s_d.mw    = i_mem_write;
    s_d.rd    = i_rd;
    s_d.pc    = i_pc_p4;
    s_d.rs    = i_res_src;
    s_d.f3    = i_funct3;
    s_d.rs2   = i_rs2_val;
    if (i_flush | fpend_q) s_d = '0;
  end

  // Flush that arrives mid-access is remembered until it completes
  always_comb begin
    fpend_d = 1'b0;
    if (o_stall) fpend_d = fpend_q | i_flush;
  end

  // Bus FSM: zero-wait in IDLE, counted WAIT, one-cycle ABORT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req & ~i_dbus_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[CW-1:0];
        if (i_dbus_ack)  state_d = S_IDLE;
        else if (hit)    state_d = S_ABORT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage register holds while stalled
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       s_q <= '0;
    else if (!o_stall) s_q <= s_d;
  end

  // FSM, wait counter and flush-pending state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
    end
  end

endmodule

// File: tb/tb_rv_memory.sv
// tb_rv_memory: directed scenario bench for rv_memory.
// Each task drives one scenario and checks hand-computed values.
module tb_rv_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] alu;
  logic        rw, mr, mw;
  logic [4:0]  rd;
  logic [29:0] pc;
  logic [1:0]  rs;
  logic [2:0]  f3;
  logic [31:0] rs2;
  logic        ack, err;
  logic [31:0] rdata;

  logic        req, we, stall, wb_rw, mis, berr;
  logic [29:0] addr, wb_pc;
  logic [3:0]  be;
  logic [31:0] wdata, wb_alu, mdata;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_rs;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv_memory #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_alu_result(alu), .i_reg_write(rw),
    .i_mem_read(mr), .i_mem_write(mw),
    .i_rd(rd), .i_pc_p4(pc), .i_res_src(rs),
    .i_funct3(f3), .i_rs2_val(rs2),
    .i_dbus_ack(ack), .i_dbus_err(err),
    .i_dbus_rdata(rdata),
    .o_dbus_req(req), .o_dbus_we(we),
    .o_dbus_addr(addr), .o_dbus_be(be),
    .o_dbus_wdata(wdata), .o_stall(stall),
    .o_rd(wb_rd), .o_reg_write(wb_rw),
    .o_res_src(wb_rs), .o_pc_p4(wb_pc),
    .o_alu_result(wb_alu), .o_mem_data(mdata),
    .o_misalign(mis), .o_bus_err(berr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w,
                       input logic wr, input logic [2:0] f,
                       input logic [31:0] ad, input logic [31:0] d);
    mr = r; mw = w; rw = wr; f3 = f; alu = ad; rs2 = d;
    rd = 5'd7; rs = 2'b01; pc = 30'h100;
  endtask

  task automatic idle_in();
    mr = 0; mw = 0; rw = 0; f3 = 0; alu = 0; rs2 = 0;
    rd = 0; rs = 0; pc = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick(); #2;
    vec++;
    if ({req, stall, wb_rw, mis, berr} !== 5'b0) begin
      bad++;
      $display("FAIL rst_ctl got %b want 00000",
               {req, stall, wb_rw, mis, berr});
    end
    vec++;
    if ({be, wdata, mdata, wb_alu} !== 100'h0) begin
      bad++;
      $display("FAIL rst_data be=%h wd=%h md=%h alu=%h want 0",
               be, wdata, mdata, wb_alu);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_lb();
    issue(1, 0, 1, 3'b000, 32'h1003, 0);
    tick();
    idle_in(); ack = 1; rdata = 32'h80AABBCC; #2;
    vec++;
    if ({req, stall, wb_rw} !== 3'b101) begin
      bad++;
      $display("FAIL lb_ctl req/stall/rw got %b want 101",
               {req, stall, wb_rw});
    end
    vec++;
    if (be !== 4'b1000) begin
      bad++; $display("FAIL lb_be got %b want 1000", be);
    end
    vec++;
    if (mdata !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_data got %h want ffffff80", mdata);
    end
    vec++;
    if (addr !== 30'h400 || wb_rd !== 5'd7) begin
      bad++;
      $display("FAIL lb_addr got %h/%0d want 400/7", addr, wb_rd);
    end
    tick(); ack = 0; #2;
    vec++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL lb_after_req got %b want 0", req);
    end
  endtask

  task automatic test_lhu_wait();
    issue(1, 0, 1, 3'b101, 32'h2002, 0);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #2;
      vec++;
      if ({stall, req, wb_rw} !== 3'b110 || addr !== 30'h800 ||
          be !== 4'b1100) begin
        bad++;
        $display("FAIL lhu_wait%0d s/r/w=%b a=%h be=%b want 110 800 1100",
                 i, {stall, req, wb_rw}, addr, be);
      end
      tick();
    end
    ack = 1; rdata = 32'hBEEF1234; #2;
    vec++;
    if ({stall, wb_rw} !== 2'b01 || mdata !== 32'h0000BEEF) begin
      bad++;
      $display("FAIL lhu_done s/w=%b md=%h want 01 0000beef",
               {stall, wb_rw}, mdata);
    end
    tick(); ack = 0;
  endtask

  task automatic test_store();
    issue(0, 1, 0, 3'b000, 32'h3001, 32'h000000A5);
    tick();
    idle_in(); ack = 1; #2;
    vec++;
    if ({req, we} !== 2'b11 || be !== 4'b0010 ||
        wdata !== 32'hA5A5A5A5 || addr !== 30'hC00) begin
      bad++;
      $display("FAIL sb r/w=%b be=%b wd=%h a=%h want 11 0010 a5a5a5a5 c00",
               {req, we}, be, wdata, addr);
    end
    issue(0, 1, 0, 3'b010, 32'h3000, 32'h12345678);
    tick();
    idle_in(); #2;
    vec++;
    if ({req, we} !== 2'b11 || be !== 4'b1111 ||
        wdata !== 32'h12345678) begin
      bad++;
      $display("FAIL sw r/w=%b be=%b wd=%h want 11 1111 12345678",
               {req, we}, be, wdata);
    end
    tick(); ack = 0;
  endtask

  task automatic test_misalign();
    issue(1, 0, 1, 3'b010, 32'h4002, 0);
    tick();
    idle_in(); #2;
    vec++;
    if ({mis, req, stall, wb_rw} !== 4'b1000) begin
      bad++;
      $display("FAIL mis m/r/s/w got %b want 1000",
               {mis, req, stall, wb_rw});
    end
    tick(); #2;
    vec++;
    if (mis !== 1'b0) begin
      bad++; $display("FAIL mis_pulse got %b want 0", mis);
    end
  endtask

  task automatic test_timeout();
    issue(1, 0, 1, 3'b010, 32'h5000, 0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      #2;
      vec++;
      if ({stall, berr} !== 2'b10) begin
        bad++;
        $display("FAIL to_wait%0d s/e got %b want 10",
                 i, {stall, berr});
      end
      tick();
    end
    #2;
    vec++;
    if ({berr, req, stall, wb_rw} !== 4'b1000) begin
      bad++;
      $display("FAIL to_abort e/r/s/w got %b want 1000",
               {berr, req, stall, wb_rw});
    end
    tick(); #2;
    vec++;
    if (berr !== 1'b0) begin
      bad++; $display("FAIL to_pulse got %b want 0", berr);
    end
    issue(1, 0, 1, 3'b010, 32'h6000, 0);
    tick();
    idle_in(); ack = 1; err = 1; #2;
    vec++;
    if ({berr, wb_rw, stall} !== 3'b100) begin
      bad++;
      $display("FAIL err_ack e/w/s got %b want 100",
               {berr, wb_rw, stall});
    end
    tick(); ack = 0; err = 0;
  endtask

  task automatic test_flush();
    issue(1, 0, 1, 3'b010, 32'h7000, 0);
    tick();
    idle_in(); #2;
    tick();
    flush = 1; #2;
    vec++;
    if ({req, stall} !== 2'b11) begin
      bad++;
      $display("FAIL fl_w2 r/s got %b want 11", {req, stall});
    end
    tick();
    flush = 0; #2;
    vec++;
    if ({req, stall} !== 2'b11 || addr !== 30'h1C00) begin
      bad++;
      $display("FAIL fl_w3 r/s=%b a=%h want 11 1c00",
               {req, stall}, addr);
    end
    tick();
    ack = 1; rdata = 32'h11223344;
    issue(0, 0, 1, 3'b000, 32'hDEADBEEF, 0); #2;
    vec++;
    if ({stall, wb_rw} !== 2'b00) begin
      bad++;
      $display("FAIL fl_ack s/w got %b want 00", {stall, wb_rw});
    end
    tick();
    ack = 0; idle_in(); #2;
    vec++;
    if (wb_alu !== 32'h0 || wb_rw !== 1'b0) begin
      bad++;
      $display("FAIL fl_clear alu=%h w=%b want 0 0", wb_alu, wb_rw);
    end
    tick();
    issue(1, 0, 1, 3'b010, 32'h8000, 0);
    tick();
    ack = 1; flush = 1;
    issue(0, 0, 1, 3'b000, 32'h11, 0); #2;
    vec++;
    if ({req, stall, wb_rw} !== 3'b100) begin
      bad++;
      $display("FAIL fl_same r/s/w got %b want 100",
               {req, stall, wb_rw});
    end
    tick();
    ack = 0; flush = 0; idle_in(); #2;
    vec++;
    if (wb_alu !== 32'h0) begin
      bad++; $display("FAIL fl_same_clr got %h want 0", wb_alu);
    end
    tick();
  endtask

  task automatic test_async_reset();
    issue(1, 0, 1, 3'b010, 32'h9000, 0);
    tick();
    idle_in(); #2;
    tick(); #2;
    rst = 1; #1;
    vec++;
    if ({req, stall, wb_rw, berr} !== 4'b0 || wb_alu !== 32'h0 ||
        be !== 4'b0) begin
      bad++;
      $display("FAIL arst r/s/w/e=%b alu=%h be=%b want 0",
               {req, stall, wb_rw, berr}, wb_alu, be);
    end
    tick();
    rst = 0;
    issue(1, 0, 1, 3'b010, 32'hA000, 0);
    tick();
    idle_in(); ack = 1; rdata = 32'hCAFEF00D; #2;
    vec++;
    if ({stall, wb_rw, berr} !== 3'b010 ||
        mdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL arst_idle s/w/e=%b md=%h want 010 cafef00d",
               {stall, wb_rw, berr}, mdata);
    end
    tick(); ack = 0;
  endtask

  initial begin
    rst = 1; flush = 0; ack = 0; err = 0; rdata = 0;
    idle_in();
    test_reset();
    test_lb();
    test_lhu_wait();
    test_store();
    test_misalign();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/rv_memory.md
# rv_memory

Memory-access pipeline stage between `rv_exec` and the write-back stage. Registers the execute results and drives a single-outstanding request/acknowledge data bus for loads and stores. It generates byte enables and store-data lane replication, and aligns and sign/zero-extends load data. It stalls the upstream pipeline while a bus access is pending and reports misaligned accesses and bus errors/timeouts.

## Interface
- `TIMEOUT`, 255: cycles in WAIT without ack before abort; 0 disables the timeout.

- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_flush` in 1: discard the instruction being captured or held.
- `i_alu_result` in 32: address for loads/stores; result for others.
- `i_reg_write`, `i_mem_read`, `i_mem_write` in 1 each: control from execute.
- `i_rd` in 5, `i_pc_p4` in 30 ([31:2]), `i_res_src` in 2, `i_funct3` in 3, `i_rs2_val` in 32: execute outputs.
- `i_dbus_ack` in 1: bus completes the access this cycle.
- `i_dbus_err` in 1: qualified by ack; access faulted.
- `i_dbus_rdata` in 32: read data, valid with ack.
- `o_dbus_req` out 1: request.
- `o_dbus_we` out 1: 1 = store.
- `o_dbus_addr` out 30 ([31:2]): word address.
- `o_dbus_be` out 4: byte enables.
- `o_dbus_wdata` out 32: store data.
- `o_stall` out 1: hold upstream stages and the stage register.
- `o_rd` out 5, `o_reg_write` out 1, `o_res_src` out 2, `o_pc_p4` out 30: to write-back.
- `o_alu_result` out 32: to write-back; also the memory-stage bypass value for execute.
- `o_mem_data` out 32: formatted load data.
- `o_misalign` out 1: misaligned access; one-cycle pulse.
- `o_bus_err` out 1: error or timeout; one-cycle pulse.

## Operation
- **Stage register S** holds all `i_*` execute fields plus a valid bit.
  - Loads on each clock edge when `o_stall` = 0.
  - On `i_flush` with `o_stall` = 0, loads zero.
  - Holds while `o_stall` = 1.
- **Memory op**: S.mem_read or S.mem_write.
- **Misalign rule** (a = S.alu_result[1:0]):
  - funct3[1:0] = 01 with a[0] = 1 → misaligned.
  - funct3[1:0] = 10 with a ≠ 0 → misaligned.
  - Misaligned ops raise `o_misalign` for the cycle S holds them. No request is made, there is no stall, and `o_reg_write` = 0.
- **Bus outputs**, combinational from S:
  - `o_dbus_req` = memory op & ~misalign & ~aborted.
  - `o_dbus_addr` = S.alu_result[31:2]; `o_dbus_we` = S.mem_write.
  - SB: be = 0001 << a; wdata = rs2[7:0] replicated 4×.
  - SH: be = 0011 << a; wdata = rs2[15:0] replicated 2×.
  - SW: be = 1111; wdata = rs2.
  - Loads: be = the same pattern as the store of equal width.
- **Load formatting** (`o_mem_data`, from `i_dbus_rdata`):
  - Select byte/half at offset a.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 → 0.
- **FSM**:
  - IDLE:
    - req & ack → stay IDLE (zero-wait access).
    - req & ~ack → WAIT; counter cleared.
  - WAIT:
    - Counter increments each cycle.
    - ack → IDLE.
    - TIMEOUT ≠ 0 and counter = TIMEOUT−1 without ack → ABORT.
  - ABORT: one cycle; req = 0, stall = 0, `o_bus_err` = 1, `o_reg_write` = 0; then → IDLE.
- `o_stall` = req & ~ack.
- **Errors**: ack with `i_dbus_err` → `o_bus_err` = 1 in that cycle and `o_reg_write` = 0.
- **Flush during an access** (`i_flush` while `o_stall` = 1):
  - Set flush-pending; the request stays asserted and stable until ack or timeout.
  - On completion, `o_reg_write` = 0 and S loads zero instead of the upstream value.
  - The pending flag then clears.
- **Write-back outputs**:
  - `o_rd`, `o_res_src`, `o_pc_p4`, `o_alu_result` = S fields.
  - `o_reg_write` = S.reg_write & ~stall & ~misalign & ~error & ~flush-pending.

## Timing
- Reset (async, immediate): S = 0, state IDLE, counter = 0, flush-pending = 0.
- All outputs 0 at reset, including `o_dbus_req`, `o_stall`, `o_reg_write`, `o_misalign` and `o_bus_err`.
- Latency: one register stage.
  - Zero-wait access: the instruction occupies the stage for 1 cycle.
  - N wait states: 1+N cycles, with `o_stall` high for N cycles.
- While `o_stall` = 1, `o_dbus_req`, `o_dbus_addr`, `o_dbus_we`, `o_dbus_be` and `o_dbus_wdata` must remain stable.
- Only one access is outstanding; a new request may be asserted in the cycle after an ack.
- Timeout: `o_bus_err` goes high in the cycle after WAIT has counted TIMEOUT cycles.
- Ack and `i_flush` in the same cycle: the instruction completes with reg_write suppressed; S is then cleared.

## Test plan
- LB, addr 0x1003, rdata 0x80AABBCC, ack same cycle → `o_be` = 1000, `o_mem_data` = 0xFFFFFF80, `o_reg_write` = 1, no stall.
- LHU, addr 0x2002, ack after 3 cycles, rdata 0xBEEF1234 → `o_stall` high 3 cycles with req/addr stable, `o_mem_data` = 0x0000BEEF.
- SB, addr 0x3001, rs2 = 0x000000A5 → req, we = 1, be = 0010, wdata = 0xA5A5A5A5; SW at 0x3000 → be = 1111.
- LW at 0x4002 → `o_misalign` pulse, no req, no stall, `o_reg_write` = 0.
- TIMEOUT = 4, no ack → stall for 4 cycles, then `o_bus_err` 1-cycle pulse with req low and `o_reg_write` = 0; ack with `i_dbus_err` → `o_bus_err` in the ack cycle.
- `i_flush` in the 2nd wait cycle of a load, ack in the 4th → req held until ack, `o_reg_write` = 0, S = 0 next cycle.
- Async reset asserted mid-WAIT → all outputs 0 immediately, FSM IDLE.
